// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic pipeline-stage register with a valid/ready handshake. It carries an
//   arbitrary packed payload between two core stages, and it has the following
//   features:
//     - synchronous flush;
//     - optional zeroing of payload on reset/flush;
//     - a saturating stall counter for performance monitoring.
//
//   SKID=1 gives a 2-entry skid buffer with a registered in_ready, for full
//   throughput. SKID=0 gives a single register with a combinational in_ready.
//
// Ports
//   clk        in   1       clock, rising edge
//   nrst       in   1       synchronous active-low reset
//   flush      in   1       synchronous kill of all held entries
//   in_valid   in   1       upstream beat valid
//   in_ready   out  1       stage can accept a beat
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       downstream beat valid
//   out_ready  in   1       downstream accepts
//   out_data   out  DATA_W  payload of the head entry
//   occupancy  out  2       entries held (0..2 with SKID=1, 0..1 with SKID=0)
//   stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0 (saturating)
//   stall_clr  in   1       synchronous clear of stall_cnt

module pipe_stage_reg #(
    parameter int DATA_W        = 32,
    parameter int SKID          = 1,
    parameter int CLEAR_PAYLOAD = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_mainNext;
    logic [DATA_W-1:0] w_skidNext;
    logic [CNT_W-1:0]  r_stallCnt;
    logic              w_readyBase;
    logic              w_accept;
    logic              w_pop;

    // With SKID=1, readiness depends only on the state flop, so there is no
    // path from out_ready. Reset and flush both block acceptance.
    always_comb begin
        if (SKID != 0) begin
            w_readyBase = (r_state != TWO);
        end else begin
            w_readyBase = (r_state == EMPTY) | out_ready;
        end
    end

    assign in_ready  = w_readyBase & nrst & ~flush;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign occupancy = r_state;
    assign stall_cnt = r_stallCnt;
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Next-state logic. The main register is always the head of the queue, and
    // the skid register holds the second entry. This preserves beat order.
    always_comb begin
        w_stateNext = r_state;
        w_mainNext  = r_main;
        w_skidNext  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_stateNext = ONE;
                    w_mainNext  = in_data;
                end
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    w_mainNext = in_data;
                end else if (w_accept) begin
                    // Only reachable with SKID=1; SKID=0 requires out_ready to accept when full.
                    w_stateNext = TWO;
                    w_skidNext  = in_data;
                end else if (w_pop) begin
                    w_stateNext = EMPTY;
                end
            end
            TWO: begin
                if (w_pop) begin
                    w_stateNext = ONE;
                    w_mainNext  = r_skid;
                end
            end
            default: begin
                w_stateNext = EMPTY;
            end
        endcase
    end

    // With CLEAR_PAYLOAD=0, reset and flush leave the payload untouched.
    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            r_state <= EMPTY;
            if (CLEAR_PAYLOAD != 0) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else begin
            r_state <= w_stateNext;
            r_main  <= w_mainNext;
            r_skid  <= w_skidNext;
        end
    end

    // A clear has priority over a simultaneous increment. Flush does not clear the count.
    always_ff @(posedge clk) begin
        if (!nrst || stall_clr) begin
            r_stallCnt <= '0;
        end else if (out_valid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

endmodule
